// File: rtl/alu_pkg.sv
// Shared constants for the MIPS-style ALU: data width, primary opcodes and
// R-type function codes, plus the immediate sign-extension helper.
// Purely declarative; no logic or latency of its own.
package alu_pkg;

    localparam int DATA_W = 32;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_BLEZ  = 6'b000110;
    localparam logic [5:0] OP_BGTZ  = 6'b000111;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_SRA   = 6'b000011;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_SRLV  = 6'b000110;
    localparam logic [5:0] FN_SRAV  = 6'b000111;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_XOR   = 6'b100110;
    localparam logic [5:0] FN_NOR   = 6'b100111;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    function automatic logic [DATA_W-1:0] sext16(input logic [15:0] imm);
        return {{(DATA_W-16){imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational MIPS ALU datapath: decodes OPCODE/FUNC and produces the next
// result and branch-taken flag. Latency 0 (pure logic); no backpressure.
// Ports: opcode/rs_val/rt_val/shamt/func/raw_val in; res_nxt/sig_b_nxt out.
module alu_core
    import alu_pkg::*;
(
    input  logic [5:0]        opcode,
    input  logic [DATA_W-1:0] rs_val,
    input  logic [DATA_W-1:0] rt_val,
    input  logic [4:0]        shamt,
    input  logic [5:0]        func,
    input  logic [15:0]       raw_val,
    output logic [DATA_W-1:0] res_nxt,
    output logic              sig_b_nxt
);

    logic [DATA_W-1:0]        imm_sext;
    logic [DATA_W-1:0]        imm_zext;
    logic [DATA_W-1:0]        diff;
    logic signed [DATA_W-1:0] rt_signed;
    logic                     rs_zero;

    always_comb begin
        imm_sext  = sext16(raw_val);
        imm_zext  = {{(DATA_W-16){1'b0}}, raw_val};
        diff      = rs_val - rt_val;
        rt_signed = rt_val;
        rs_zero   = (rs_val == '0);

        res_nxt   = '0;
        sig_b_nxt = 1'b0;

        case (opcode)
            OP_RTYPE: begin
                case (func)
                    FN_ADD, FN_ADDU: res_nxt = rs_val + rt_val;
                    FN_SUB, FN_SUBU: res_nxt = diff;
                    FN_AND:          res_nxt = rs_val & rt_val;
                    FN_OR:           res_nxt = rs_val | rt_val;
                    FN_XOR:          res_nxt = rs_val ^ rt_val;
                    FN_NOR:          res_nxt = ~(rs_val | rt_val);
                    FN_SLT:  res_nxt = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(rt_val))};
                    FN_SLTU: res_nxt = {{(DATA_W-1){1'b0}}, (rs_val < rt_val)};
                    FN_SLL:          res_nxt = rt_val << shamt;
                    FN_SRL:          res_nxt = rt_val >> shamt;
                    FN_SRA:          res_nxt = rt_signed >>> shamt;
                    // Variable shifts use only the low five bits of RS.
                    FN_SLLV:         res_nxt = rt_val << rs_val[4:0];
                    FN_SRLV:         res_nxt = rt_val >> rs_val[4:0];
                    FN_SRAV:         res_nxt = rt_signed >>> rs_val[4:0];
                    default:         res_nxt = '0;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_LW, OP_SW: res_nxt = rs_val + imm_sext;
            OP_SLTI:  res_nxt = {{(DATA_W-1){1'b0}}, ($signed(rs_val) < $signed(imm_sext))};
            // SLTIU still sign-extends the immediate, then compares unsigned.
            OP_SLTIU: res_nxt = {{(DATA_W-1){1'b0}}, (rs_val < imm_sext)};
            OP_ANDI:  res_nxt = rs_val & imm_zext;
            OP_ORI:   res_nxt = rs_val | imm_zext;
            OP_XORI:  res_nxt = rs_val ^ imm_zext;
            OP_LUI:   res_nxt = {raw_val, 16'h0000};
            OP_BEQ: begin
                res_nxt   = diff;
                sig_b_nxt = (rs_val == rt_val);
            end
            OP_BNE: begin
                res_nxt   = diff;
                sig_b_nxt = (rs_val != rt_val);
            end
            OP_BLEZ: begin
                res_nxt   = diff;
                sig_b_nxt = rs_val[DATA_W-1] | rs_zero;
            end
            OP_BGTZ: begin
                res_nxt   = diff;
                sig_b_nxt = ~rs_val[DATA_W-1] & ~rs_zero;
            end
            default: begin
                res_nxt   = '0;
                sig_b_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// MIPS ALU top: registers the alu_core result and branch flag.
// Latency 1 cycle, one operation per cycle; no handshake, never stalls.
// Ports: CLK, RST (sync active-high), OPCODE/RS_VAL/RT_VAL/SHAMT/FUNC/RAW_VAL in; RESULT/SIG_B out.
module alu
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic [5:0]        OPCODE,
    input  logic [DATA_W-1:0] RS_VAL,
    input  logic [DATA_W-1:0] RT_VAL,
    input  logic [4:0]        SHAMT,
    input  logic [5:0]        FUNC,
    input  logic [15:0]       RAW_VAL,
    output logic [DATA_W-1:0] RESULT,
    output logic              SIG_B
);

    logic [DATA_W-1:0] core_res;
    logic              core_sig_b;
    logic [DATA_W-1:0] result_d;
    logic [DATA_W-1:0] result_q;
    logic              sig_b_d;
    logic              sig_b_q;

    alu_core u_core (
        .opcode    (OPCODE),
        .rs_val    (RS_VAL),
        .rt_val    (RT_VAL),
        .shamt     (SHAMT),
        .func      (FUNC),
        .raw_val   (RAW_VAL),
        .res_nxt   (core_res),
        .sig_b_nxt (core_sig_b)
    );

    // Reset wins over whatever operation is presented in the same cycle.
    always_comb begin
        result_d = core_res;
        sig_b_d  = core_sig_b;
        if (RST) begin
            result_d = '0;
            sig_b_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        result_q <= result_d;
        sig_b_q  <= sig_b_d;
    end

    assign RESULT = result_q;
    assign SIG_B  = sig_b_q;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered MIPS ALU.
// Drives inputs just after a rising edge, samples 1 time unit after the next one.
// Each scenario task compares RESULT/SIG_B against hand-computed values.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [5:0]  opcode;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  shamt;
    logic [5:0]  func;
    logic [15:0] raw_val;
    logic [31:0] result;
    logic        sig_b;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] exp_res;
        logic        exp_b;
    } vec_t;

    alu dut (
        .CLK     (clk),
        .RST     (rst),
        .OPCODE  (opcode),
        .RS_VAL  (rs_val),
        .RT_VAL  (rt_val),
        .SHAMT   (shamt),
        .FUNC    (func),
        .RAW_VAL (raw_val),
        .RESULT  (result),
        .SIG_B   (sig_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one operation, then advance past the capturing edge.
    task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [4:0] sh, input logic [15:0] imm);
        opcode  = op;
        func    = fn;
        rs_val  = rs;
        rt_val  = rt;
        shamt   = sh;
        raw_val = imm;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(6'b000000, 6'b100000, 32'd3, 32'd4, 5'd0, 16'h0);
        drive(6'b000100, 6'b000000, 32'd5, 32'd5, 5'd0, 16'h0);
        checks++;
        if (result !== 32'h0) begin
            failures++;
            $display("FAIL reset_result got=%h want=%h", result, 32'h0);
        end
        checks++;
        if (sig_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_sig_b got=%b want=%b", sig_b, 1'b0);
        end
        rst = 1'b0;
    endtask

    // Successive ANDs, one per cycle, each checked the cycle after issue.
    task automatic test_back_to_back();
        logic [31:0] rs_t [3];
        logic [31:0] rt_t [3];
        logic [31:0] ex_t [3];
        rs_t = '{32'd15, 32'd23, 32'd1};
        rt_t = '{32'd12, 32'd2,  32'd35};
        ex_t = '{32'd12, 32'd2,  32'd1};
        for (int i = 0; i < 3; i++) begin
            drive(6'b000000, 6'b100100, rs_t[i], rt_t[i], 5'd0, 16'h0);
            checks++;
            if (result !== ex_t[i] || sig_b !== 1'b0) begin
                failures++;
                $display("FAIL and_seq[%0d] got=%h/%b want=%h/0", i, result, sig_b, ex_t[i]);
            end
        end
    endtask

    task automatic run_table(input vec_t v [], input string grp);
        foreach (v[i]) begin
            drive(v[i].op, v[i].fn, v[i].rs, v[i].rt, v[i].sh, v[i].imm);
            checks++;
            if (result !== v[i].exp_res || sig_b !== v[i].exp_b) begin
                failures++;
                $display("FAIL %s_%s got=%h/%b want=%h/%b", grp, v[i].name,
                         result, sig_b, v[i].exp_res, v[i].exp_b);
            end
        end
    endtask

    task automatic test_arith();
        vec_t v [] = '{
            '{"add_wrap", 6'b000000, 6'b100000, 32'h7FFFFFFF, 32'h1, 5'd0, 16'h0, 32'h80000000, 1'b0},
            '{"addu_wrap",6'b000000, 6'b100001, 32'hFFFFFFFF, 32'h2, 5'd0, 16'h0, 32'h00000001, 1'b0},
            '{"sub",      6'b000000, 6'b100010, 32'h0,        32'h1, 5'd0, 16'h0, 32'hFFFFFFFF, 1'b0},
            '{"subu",     6'b000000, 6'b100011, 32'd10,       32'd3, 5'd0, 16'h0, 32'd7,        1'b0},
            '{"slt",      6'b000000, 6'b101010, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 32'h1,        1'b0},
            '{"sltu",     6'b000000, 6'b101011, 32'hFFFFFFFF, 32'h1, 5'd0, 16'h0, 32'h0,        1'b0},
            '{"or",       6'b000000, 6'b100101, 32'hF0F00000, 32'h0000000F, 5'd0, 16'h0, 32'hF0F0000F, 1'b0},
            '{"xor",      6'b000000, 6'b100110, 32'hFF00FF00, 32'h0FF00FF0, 5'd0, 16'h0, 32'hF0F0F0F0, 1'b0},
            '{"nor",      6'b000000, 6'b100111, 32'h0,        32'h0, 5'd0, 16'h0, 32'hFFFFFFFF, 1'b0}
        };
        run_table(v, "arith");
    endtask

    task automatic test_shifts();
        vec_t v [] = '{
            '{"sra",      6'b000000, 6'b000011, 32'h0,  32'h80000000, 5'd4, 16'h0, 32'hF8000000, 1'b0},
            '{"srl",      6'b000000, 6'b000010, 32'h0,  32'h80000000, 5'd4, 16'h0, 32'h08000000, 1'b0},
            '{"sllv",     6'b000000, 6'b000100, 32'd33, 32'h1,        5'd0, 16'h0, 32'h2,        1'b0},
            '{"srav",     6'b000000, 6'b000111, 32'd36, 32'h80000000, 5'd0, 16'h0, 32'hF8000000, 1'b0},
            '{"srlv",     6'b000000, 6'b000110, 32'd31, 32'h80000000, 5'd0, 16'h0, 32'h1,        1'b0},
            '{"sll",      6'b000000, 6'b000000, 32'h0,  32'h00000003, 5'd31, 16'h0, 32'h80000000, 1'b0},
            '{"sll_zero", 6'b000000, 6'b000000, 32'h0,  32'hA5A5A5A5, 5'd0, 16'h0, 32'hA5A5A5A5, 1'b0},
            '{"sra_zero", 6'b000000, 6'b000011, 32'h0,  32'h80000001, 5'd0, 16'h0, 32'h80000001, 1'b0}
        };
        run_table(v, "shift");
    endtask

    task automatic test_itype();
        vec_t v [] = '{
            '{"addi",  6'b001000, 6'b000000, 32'd10,       32'h0, 5'd0, 16'hFFFF, 32'd9,        1'b0},
            '{"addiu", 6'b001001, 6'b000000, 32'h7FFFFFFF, 32'h0, 5'd0, 16'h0001, 32'h80000000, 1'b0},
            '{"ori",   6'b001101, 6'b000000, 32'h0,        32'h0, 5'd0, 16'hFFFF, 32'h0000FFFF, 1'b0},
            '{"lui",   6'b001111, 6'b000000, 32'hDEADBEEF, 32'h0, 5'd0, 16'h1234, 32'h12340000, 1'b0},
            '{"slti",  6'b001010, 6'b000000, 32'd5,        32'h0, 5'd0, 16'hFFFF, 32'h0,        1'b0},
            '{"sltiu", 6'b001011, 6'b000000, 32'd5,        32'h0, 5'd0, 16'hFFFF, 32'h1,        1'b0},
            '{"andi",  6'b001100, 6'b000000, 32'hFFFFFFFF, 32'h0, 5'd0, 16'h8000, 32'h00008000, 1'b0},
            '{"xori",  6'b001110, 6'b000000, 32'hFFFFFFFF, 32'h0, 5'd0, 16'h00FF, 32'hFFFFFF00, 1'b0},
            '{"lw",    6'b100011, 6'b000000, 32'd100,      32'h0, 5'd0, 16'hFFFC, 32'd96,       1'b0},
            '{"sw",    6'b101011, 6'b000000, 32'h0,        32'h0, 5'd0, 16'h0010, 32'd16,       1'b0}
        };
        run_table(v, "itype");
    endtask

    task automatic test_branch();
        vec_t v [] = '{
            '{"beq_t",  6'b000100, 6'b000000, 32'd5,        32'd5, 5'd0, 16'h0, 32'h0,        1'b1},
            '{"bne_nt", 6'b000101, 6'b000000, 32'd5,        32'd5, 5'd0, 16'h0, 32'h0,        1'b0},
            '{"bne_t",  6'b000101, 6'b000000, 32'd5,        32'd3, 5'd0, 16'h0, 32'd2,        1'b1},
            '{"beq_nt", 6'b000100, 6'b000000, 32'd5,        32'd3, 5'd0, 16'h0, 32'd2,        1'b0},
            '{"blez_0", 6'b000110, 6'b000000, 32'h0,        32'h0, 5'd0, 16'h0, 32'h0,        1'b1},
            '{"blez_n", 6'b000110, 6'b000000, 32'h80000000, 32'h1, 5'd0, 16'h0, 32'h7FFFFFFF, 1'b1},
            '{"blez_p", 6'b000110, 6'b000000, 32'd1,        32'h0, 5'd0, 16'h0, 32'd1,        1'b0},
            '{"bgtz_n", 6'b000111, 6'b000000, 32'h80000000, 32'h0, 5'd0, 16'h0, 32'h80000000, 1'b0},
            '{"bgtz_p", 6'b000111, 6'b000000, 32'd1,        32'h0, 5'd0, 16'h0, 32'd1,        1'b1},
            '{"bgtz_0", 6'b000111, 6'b000000, 32'h0,        32'h0, 5'd0, 16'h0, 32'h0,        1'b0}
        };
        run_table(v, "branch");
    endtask

    // Each unsupported op follows a taken branch with nonzero result so that
    // both outputs must actively clear.
    task automatic test_unsupported();
        vec_t v [] = '{
            '{"pre1",    6'b000101, 6'b000000, 32'd9, 32'd1, 5'd0, 16'h0, 32'd8, 1'b1},
            '{"bad_op",  6'b111111, 6'b100000, 32'd9, 32'd1, 5'd0, 16'h1, 32'h0, 1'b0},
            '{"pre2",    6'b000101, 6'b000000, 32'd9, 32'd1, 5'd0, 16'h0, 32'd8, 1'b1},
            '{"bad_fn",  6'b000000, 6'b001000, 32'd9, 32'd1, 5'd3, 16'h0, 32'h0, 1'b0},
            '{"pre3",    6'b000101, 6'b000000, 32'd9, 32'd1, 5'd0, 16'h0, 32'd8, 1'b1},
            '{"bad_fn2", 6'b000000, 6'b000001, 32'd9, 32'd1, 5'd3, 16'h0, 32'h0, 1'b0}
        };
        run_table(v, "unsup");
    endtask

    task automatic test_reset_override();
        drive(6'b000101, 6'b000000, 32'd9, 32'd1, 5'd0, 16'h0);
        rst = 1'b1;
        drive(6'b000000, 6'b100000, 32'd3, 32'd4, 5'd0, 16'h0);
        checks++;
        if (result !== 32'h0 || sig_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_override got=%h/%b want=%h/0", result, sig_b, 32'h0);
        end
        rst = 1'b0;
        drive(6'b000000, 6'b100000, 32'd3, 32'd4, 5'd0, 16'h0);
        checks++;
        if (result !== 32'd7 || sig_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_release got=%h/%b want=%h/0", result, sig_b, 32'd7);
        end
    endtask

    initial begin
        rst     = 1'b1;
        opcode  = '0;
        func    = '0;
        rs_val  = '0;
        rt_val  = '0;
        shamt   = '0;
        raw_val = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_back_to_back();
        test_arith();
        test_shifts();
        test_itype();
        test_branch();
        test_unsupported();
        test_reset_override();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
